key_fifo: RTL and testbench
===========================

# key_fifo

Elastic buffer for the 9-bit key stream that feeds the key port of the top-level core. Sits directly upstream of the core: it accepts keys from the key source over a valid/accept handshake, stores up to `depth_p` entries, and presents them in order on the `key_valid`/`key_accept`/`key_data` handshake the core consumes. It decouples source bursts from core back-pressure and reports its fill level for status and debug.

## Interface
- `depth_p`, 4, number of entries; power of two, range 2..64
- `width_p`, 9, key data width in bits
- `level_width_p`, `$clog2(depth_p + 1)`, width of the level output (derived, not overridden)

Ports:
- `main_clk_i`  input  1  clock
- `main_rst_i`  input  1  reset; one clock; reset is asynchronous and active-high
- `flush_i`  input  1  synchronous clear of all entries
- `src_valid_i`  input  1  source presents a key
- `src_accept_o`  output  1  buffer takes the key this cycle
- `src_data_i`  input  `width_p`  source key
- `key_valid_o`  output  1  head entry available; drives the core's `key_valid_i`
- `key_accept_i`  input  1  core takes the head entry; driven by the core's `key_accept`
- `key_data_o`  output  `width_p`  head entry; drives the core's `key_data`
- `level_o`  output  `level_width_p`  number of stored entries, 0..`depth_p`
- `full_o`  output  1  `level_o == depth_p`
- `empty_o`  output  1  `level_o == 0`

## Operation
- Storage: `depth_p` x `width_p` register array, write pointer `wp`, read pointer `rp`, each `log2(depth_p)` bits, wrapping modulo `depth_p`. A separate `level` counter tracks occupancy.
- Push: `src_valid_i & src_accept_o`. The entry is written at `wp`, and `wp` increments.
- Pop: `key_valid_o & key_accept_i`. `rp` increments.
- `src_accept_o = !full_o & !flush_i`. This is independent of `src_valid_i`.
- `key_valid_o = !empty_o`. `key_data_o = mem[rp]` (combinational read of registered storage).
- Level update per cycle: push only +1; pop only -1; push and pop together, no change; neither, no change.
- Simultaneous push and pop at full is impossible, because `src_accept_o` is 0 when full. There is no write-through at full.
- Simultaneous push and pop at empty is impossible, because `key_valid_o` is 0 when empty. There is no bypass at empty.
- `flush_i` = 1: `wp`, `rp` and `level` all go to 0 at the next edge. Any push or pop in that cycle is discarded. Memory contents are not cleared.
- Handshake rules on the output side:
  - Once `key_valid_o` is high, it stays high and `key_data_o` stays stable until a pop occurs or `flush_i` is asserted.
  - `key_accept_i` may be asserted while `key_valid_o` is low; it has no effect.
- Source protocol is not checked. Data presented while `src_accept_o` = 0 is ignored.

## Timing
- Reset values (asynchronous, immediate on `main_rst_i` = 1):
  - `wp` = 0, `rp` = 0, `level_o` = 0
  - `empty_o` = 1, `full_o` = 0, `key_valid_o` = 0, `src_accept_o` = 1 (when `flush_i` = 0)
  - `key_data_o` = 0 (memory resets to 0)
- Reset asserted mid-transfer discards all entries. Deassertion is synchronised externally; the first push is accepted on the first edge after release.
- Latency: a key pushed at edge N appears on `key_data_o` with `key_valid_o` = 1 after edge N. It is consumable in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained when the buffer is neither full nor empty.
- `level_o`, `full_o` and `empty_o` are registered and reflect the state after the most recent edge.
- `src_accept_o` contains a combinational path from `flush_i` only. There is no path from `key_accept_i` to `src_accept_o`.

## Test plan
- Reset then idle: `level_o` = 0, `empty_o` = 1, `key_valid_o` = 0, `src_accept_o` = 1, `key_data_o` = 0.
- Fill then drain (`depth_p` = 4):
  - Push 0x001, 0x0A5, 0x1FF, 0x100 with `key_accept_i` = 0: `level_o` steps 1→4, `full_o` = 1, `src_accept_o` = 0.
  - Further `src_valid_i` with 0x055 is not stored.
  - Drain with `key_accept_i` = 1: order is 0x001, 0x0A5, 0x1FF, 0x100, then `empty_o` = 1.
- Wrap-around with concurrent traffic:
  - Push and pop every cycle for 10 keys 0x000..0x009 after pre-loading 2 entries.
  - `level_o` holds at 2 throughout.
  - Output order is preserved across pointer wrap.
- Stall stability: with 3 entries and `key_accept_i` = 0 for 5 cycles, `key_valid_o` stays 1 and `key_data_o` holds its value. One accept pulse pops exactly one entry and `level_o` goes to 2.
- Flush: with 3 entries, assert `flush_i` for one cycle while pushing 0x0AA. After the edge: `level_o` = 0, `key_valid_o` = 0, `src_accept_o` was 0 during the flush cycle, and 0x0AA is not stored.
- Reset mid-operation: with 2 entries and a push in progress, assert `main_rst_i` between edges. Outputs return to reset values immediately, and after release the next pushed key 0x123 is the first key popped.

Source files
------------

// File: rtl/key_fifo.sv
// Elastic buffer for the 9-bit key stream feeding the core's key port.
// Register-array FIFO with separate occupancy counter; registered level/full/empty.
module key_fifo #(
  parameter int unsigned depth_p       = 4,
  parameter int unsigned width_p       = 9,
  parameter int unsigned level_width_p = $clog2(depth_p + 1)
) (
  input  logic                     main_clk_i,
  input  logic                     main_rst_i,
  input  logic                     flush_i,
  input  logic                     src_valid_i,
  output logic                     src_accept_o,
  input  logic [width_p-1:0]       src_data_i,
  output logic                     key_valid_o,
  input  logic                     key_accept_i,
  output logic [width_p-1:0]       key_data_o,
  output logic [level_width_p-1:0] level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(depth_p);
  localparam logic [level_width_p-1:0] LevelFull = level_width_p'(depth_p);

  logic [width_p-1:0]       mem_q [depth_p];
  logic [PtrW-1:0]          wp_q, wp_d;
  logic [PtrW-1:0]          rp_q, rp_d;
  logic [level_width_p-1:0] level_q, level_d;
  logic                     push, pop;

  assign level_o      = level_q;
  assign full_o       = (level_q == LevelFull);
  assign empty_o      = (level_q == '0);
  assign src_accept_o = !full_o && !flush_i;
  assign key_valid_o  = !empty_o;
  assign key_data_o   = mem_q[rp_q];

  assign push = src_valid_i && src_accept_o;
  // A pop in the flush cycle is discarded along with everything else.
  assign pop  = key_valid_o && key_accept_i && !flush_i;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage is not cleared by flush, only by reset.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      for (int unsigned i = 0; i < depth_p; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wp_q] <= src_data_i;
    end
  end

endmodule

// File: tb/tb_key_fifo.sv
// Scoreboard bench for key_fifo: driver updates a queue model and expected-key queue,
// a negedge monitor compares flags, level and every popped key.
module tb_key_fifo;
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic       src_valid_i;
  logic       src_accept_o;
  logic [8:0] src_data_i;
  logic       key_valid_o;
  logic       key_accept_i;
  logic [8:0] key_data_o;
  logic [2:0] level_o;
  logic       full_o;
  logic       empty_o;

  key_fifo dut (
    .main_clk_i  (clk),
    .main_rst_i  (rst),
    .flush_i     (flush_i),
    .src_valid_i (src_valid_i),
    .src_accept_o(src_accept_o),
    .src_data_i  (src_data_i),
    .key_valid_o (key_valid_o),
    .key_accept_i(key_accept_i),
    .key_data_o  (key_data_o),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] mdl[$];    // reference contents after the most recent edge
  logic [8:0] exp_q[$];  // scoreboard: keys expected to be popped, in order
  int         exp_level = 0;
  logic       mon_en = 1'b0;
  logic       hold = 1'b0;
  logic [8:0] held = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One cycle of stimulus; the model advances by the buffer's rules.
  task automatic drive(input logic v, input logic [8:0] d, input logic a, input logic f);
    bit push_ok, pop_ok;
    @(posedge clk);
    #1;
    src_valid_i  = v;
    src_data_i   = d;
    key_accept_i = a;
    flush_i      = f;
    exp_level    = mdl.size();
    push_ok      = v && !f && (mdl.size() < Depth);
    pop_ok       = a && !f && (mdl.size() > 0);
    if (f) begin
      mdl.delete();
      exp_q.delete();
    end else begin
      if (pop_ok) void'(mdl.pop_front());
      if (push_ok) begin
        mdl.push_back(d);
        exp_q.push_back(d);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("level", 32'(level_o), 32'(exp_level));
        check("empty", 32'(empty_o), 32'(exp_level == 0));
        check("full", 32'(full_o), 32'(exp_level == Depth));
        check("key_valid", 32'(key_valid_o), 32'(exp_level > 0));
        check("src_accept", 32'(src_accept_o), 32'((exp_level < Depth) && !flush_i));
        if (hold) check("stall_data", 32'(key_data_o), 32'(held));
        if (key_valid_o && key_accept_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_underflow: got %0h expected no pop at %0t", key_data_o, $time);
          end else begin
            check("pop_data", 32'(key_data_o), 32'(exp_q.pop_front()));
          end
        end
        hold = key_valid_o && !key_accept_i && !flush_i;
        held = key_data_o;
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    src_valid_i = 1'b0;
    src_data_i = '0;
    key_accept_i = 1'b0;
    #1;
    check("rst_level", 32'(level_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_valid", 32'(key_valid_o), 0);
    check("rst_accept", 32'(src_accept_o), 1);
    check("rst_data", 32'(key_data_o), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fill, overfill attempt, drain.
    drive(1, 9'h001, 0, 0);
    drive(1, 9'h0A5, 0, 0);
    drive(1, 9'h1FF, 0, 0);
    drive(1, 9'h100, 0, 0);
    drive(1, 9'h055, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 0, 0);

    // Concurrent push/pop across pointer wrap, level holding at 2.
    drive(1, 9'h150, 0, 0);
    drive(1, 9'h151, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 9'(i), 1, 0);
    drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 0, 0);

    // Stall stability, then a single accept pulse.
    drive(1, 9'h011, 0, 0);
    drive(1, 9'h022, 0, 0);
    drive(1, 9'h033, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 9'h000, 0, 0);
    drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 0, 0);

    // Back to 3 entries, then flush while pushing 0x0AA.
    drive(1, 9'h044, 0, 0);
    drive(1, 9'h0AA, 0, 1);
    drive(0, 9'h000, 0, 0);
    drive(0, 9'h000, 1, 0);

    // Reset between edges with 2 entries and a push in progress.
    drive(1, 9'h061, 0, 0);
    drive(1, 9'h062, 0, 0);
    drive(1, 9'h063, 0, 0);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    src_valid_i = 1'b0;
    #1;
    check("midrst_level", 32'(level_o), 0);
    check("midrst_empty", 32'(empty_o), 1);
    check("midrst_full", 32'(full_o), 0);
    check("midrst_valid", 32'(key_valid_o), 0);
    check("midrst_accept", 32'(src_accept_o), 1);
    check("midrst_data", 32'(key_data_o), 0);
    mdl.delete();
    exp_q.delete();
    exp_level = 0;
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    drive(1, 9'h123, 0, 0);
    drive(1, 9'h124, 1, 0);
    drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 0, 0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < Depth + 1; i++) drive(0, 9'h000, 1, 0);
    drive(0, 9'h000, 0, 0);
    @(posedge clk);
    #1;
    check("final_scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
